// File: rtl/spi_rxbuf_ctrl_pkg.sv
// Shared definitions for the SPI receive buffer controller:
// FSM state encoding, CPU register offsets and STATUS bit positions.
package spi_rxbuf_ctrl_pkg;

  typedef enum logic [1:0] {
    RXB_IDLE = 2'd0,
    RXB_RECV = 2'd1,
    RXB_DONE = 2'd2
  } rxb_state_e;

  // Register offsets relative to REG_BASE
  localparam logic [7:0] REG_STATUS = 8'd0;
  localparam logic [7:0] REG_LEN    = 8'd1;
  localparam logic [7:0] REG_DROP   = 8'd2;

  // STATUS register bit indices
  localparam int ST_DONE = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_RECV = 2;

  // RELEASE command bit in a STATUS write
  localparam int CMD_RELEASE = 0;

endpackage

// File: rtl/spi_rxbuf_ram.sv
// Receive buffer storage: 2**AW x 8, synchronous write from the SPI side,
// asynchronous read addressed by the (already registered) CPU address.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module spi_rxbuf_ram #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_rxbuf_ctrl.sv
// Receive-side packet buffer for the SPI slave link. Captures one CS-framed
// packet into a 2**AW byte RAM and holds it until the CPU releases it;
// packets that arrive while a packet is held are dropped and counted.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   rxPacketStart  - level, current rx byte is the first of a packet
//   rxData         - received byte, qualified by rxDataRdySet
//   rxDataRdySet   - 1-cycle new-byte strobe
//   rxPacketEnd    - 1-cycle end-of-packet strobe (CS deasserted)
//   cpu_addr/di/wr/rd - 8-bit CPU bus; reads have no side effects
//   cpu_do         - read data, one cycle after cpu_addr
//   rx_irq         - high while a complete packet is held
module spi_rxbuf_ctrl
  import spi_rxbuf_ctrl_pkg::*;
#(
  parameter int         AW       = 5,
  parameter logic [7:0] REG_BASE = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxPacketStart,
  input  logic [7:0] rxData,
  input  logic       rxDataRdySet,
  input  logic       rxPacketEnd,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_di,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  output logic [7:0] cpu_do,
  output logic       rx_irq
);

  rxb_state_e  state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;   // one extra bit so a full buffer reads as 2**AW
  logic [AW:0] len_q, len_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  addr_q;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_rdata;

  logic start_byte, release_cmd;
  logic [7:0] unused_bits;

  assign start_byte  = rxDataRdySet && rxPacketStart;
  assign release_cmd = cpu_wr && (cpu_addr == REG_BASE + REG_STATUS) && cpu_di[CMD_RELEASE];
  assign unused_bits = {cpu_rd, cpu_di[7:1]};

  spi_rxbuf_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (rxData),
    .raddr (addr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RXB_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      addr_q   <= cpu_addr;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    unique case (state_q)
      RXB_IDLE: begin
        if (start_byte) begin
          ram_we   = 1'b1;
          wr_ptr_d = (AW+1)'(1);
          ovf_d    = 1'b0;
          state_d  = RXB_RECV;
        end
      end
      RXB_RECV: begin
        // A new start byte inside a packet discards what was collected so far
        if (start_byte) begin
          ram_we   = 1'b1;
          wr_ptr_d = (AW+1)'(1);
          ovf_d    = 1'b0;
        end else if (rxDataRdySet && !wr_ptr_q[AW]) begin
          ram_we    = 1'b1;
          ram_waddr = wr_ptr_q[AW-1:0];
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end else if (rxDataRdySet) begin
          ovf_d = 1'b1;
        end
        // Length includes a byte strobed in the same cycle as the end
        if (rxPacketEnd) begin
          len_d   = wr_ptr_d;
          state_d = RXB_DONE;
        end
      end
      RXB_DONE: begin
        // Start byte counts as a drop even when release lands the same cycle
        if (start_byte && drop_q != 8'hFF) drop_d = drop_q + 1'b1;
        if (release_cmd) state_d = RXB_IDLE;
      end
      default: state_d = RXB_IDLE;
    endcase
  end

  assign rx_irq = (state_q == RXB_DONE);

  always_comb begin
    cpu_do = 8'h00;
    if (addr_q[7:AW] == '0) begin
      cpu_do = ram_rdata;
    end else if (addr_q == REG_BASE + REG_STATUS) begin
      cpu_do[ST_DONE] = (state_q == RXB_DONE);
      cpu_do[ST_OVF]  = ovf_q;
      cpu_do[ST_RECV] = (state_q == RXB_RECV);
    end else if (addr_q == REG_BASE + REG_LEN) begin
      cpu_do = {{(7-AW){1'b0}}, len_q};
    end else if (addr_q == REG_BASE + REG_DROP) begin
      cpu_do = drop_q;
    end
  end

endmodule
